// File: rtl/zap_predecode_queue.sv
// zap_predecode_queue: DEPTH-entry show-ahead queue between predecode and decode,
// with the stall/clear priority chain and push back-pressure.
module zap_predecode_queue #(
    parameter int IW    = 35,
    parameter int DEPTH = 4,
    parameter int PCW   = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clear_from_writeback,
    input  logic           i_data_stall,
    input  logic           i_clear_from_alu,
    input  logic           i_stall_downstream,
    input  logic           i_clear_from_decode,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [IW-1:0]  i_instruction,
    input  logic [PCW-1:0] i_pc_ff,
    input  logic [PCW-1:0] i_pc_plus_8_ff,
    input  logic [1:0]     i_taken,
    input  logic           i_irq,
    input  logic           i_fiq,
    input  logic           i_iabort,
    input  logic           i_und,
    input  logic           i_force32_align,
    output logic           o_valid,
    output logic [IW-1:0]  o_instruction,
    output logic [PCW-1:0] o_pc_ff,
    output logic [PCW-1:0] o_pc_plus_8_ff,
    output logic [1:0]     o_taken_ff,
    output logic           o_irq,
    output logic           o_fiq,
    output logic           o_iabort,
    output logic           o_und,
    output logic           o_force32_align,
    output logic [CW-1:0]  o_count
);
    localparam int EW = IW + 2 * PCW + 7;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          flush, active, push, pop;
    logic          h_irq, h_fiq, h_iabort, h_und;

    always_comb begin
        flush   = i_clear_from_writeback ||
                  (!i_data_stall && (i_clear_from_alu || (!i_stall_downstream && i_clear_from_decode)));
        // active covers the stall_downstream row (push only) and the normal row
        active  = !i_reset && !i_clear_from_writeback && !i_data_stall && !i_clear_from_alu &&
                  (i_stall_downstream || !i_clear_from_decode);
        pop     = active && o_valid && !i_stall_downstream;
        o_ready = !i_data_stall && (count < CW'(DEPTH) || pop);
        push    = active && i_valid && o_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {i_instruction, i_pc_ff, i_pc_plus_8_ff, i_taken,
                            i_irq, i_fiq, i_iabort, i_und, i_force32_align};
    end

    assign {o_instruction, o_pc_ff, o_pc_plus_8_ff, o_taken_ff,
            h_irq, h_fiq, h_iabort, h_und, o_force32_align} = mem[rd_ptr];

    assign o_valid  = count != '0;
    assign o_irq    = h_irq & o_valid;
    assign o_fiq    = h_fiq & o_valid;
    assign o_iabort = h_iabort & o_valid;
    assign o_und    = h_und & o_valid;
    assign o_count  = count;
endmodule

// File: tb/tb_zap_predecode_queue.sv
// tb_zap_predecode_queue: directed plan plus random traffic against a queue-based model.
module tb_zap_predecode_queue;
    localparam int IW = 35, DEPTH = 4, PCW = 32, CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0]  ins;
        logic [PCW-1:0] pc;
        logic [PCW-1:0] pc8;
        logic [1:0]     tk;
        logic           irq, fiq, iab, und, f32;
    } ent_t;

    logic           i_clk = 0, i_reset = 0, i_clear_from_writeback = 0, i_data_stall = 0;
    logic           i_clear_from_alu = 0, i_stall_downstream = 0, i_clear_from_decode = 0;
    logic           i_valid = 0, o_ready;
    logic [IW-1:0]  i_instruction = '0;
    logic [PCW-1:0] i_pc_ff = '0, i_pc_plus_8_ff = '0;
    logic [1:0]     i_taken = '0;
    logic           i_irq = 0, i_fiq = 0, i_iabort = 0, i_und = 0, i_force32_align = 0;
    logic           o_valid, o_irq, o_fiq, o_iabort, o_und, o_force32_align;
    logic [IW-1:0]  o_instruction;
    logic [PCW-1:0] o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]     o_taken_ff;
    logic [CW-1:0]  o_count;

    int   total = 0, bad = 0;
    ent_t q[$];

    zap_predecode_queue #(.IW(IW), .DEPTH(DEPTH), .PCW(PCW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear_from_writeback(i_clear_from_writeback),
        .i_data_stall(i_data_stall), .i_clear_from_alu(i_clear_from_alu),
        .i_stall_downstream(i_stall_downstream), .i_clear_from_decode(i_clear_from_decode),
        .i_valid(i_valid), .o_ready(o_ready), .i_instruction(i_instruction), .i_pc_ff(i_pc_ff),
        .i_pc_plus_8_ff(i_pc_plus_8_ff), .i_taken(i_taken), .i_irq(i_irq), .i_fiq(i_fiq),
        .i_iabort(i_iabort), .i_und(i_und), .i_force32_align(i_force32_align),
        .o_valid(o_valid), .o_instruction(o_instruction), .o_pc_ff(o_pc_ff),
        .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff), .o_irq(o_irq), .o_fiq(o_fiq),
        .o_iabort(o_iabort), .o_und(o_und), .o_force32_align(o_force32_align), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level behaviour: priority rows decide flush / hold / push-only / push+pop.
    task automatic model_step();
        ent_t e;
        logic pop_m, rdy;
        e.ins = i_instruction; e.pc = i_pc_ff; e.pc8 = i_pc_plus_8_ff; e.tk = i_taken;
        e.irq = i_irq; e.fiq = i_fiq; e.iab = i_iabort; e.und = i_und; e.f32 = i_force32_align;
        if (i_reset || i_clear_from_writeback) q.delete();
        else if (i_data_stall) begin end
        else if (i_clear_from_alu) q.delete();
        else if (i_stall_downstream) begin
            if (i_valid && q.size() < DEPTH) q.push_back(e);
        end
        else if (i_clear_from_decode) q.delete();
        else begin
            pop_m = q.size() > 0;
            rdy   = q.size() < DEPTH || pop_m;
            if (pop_m) void'(q.pop_front());
            if (i_valid && rdy) q.push_back(e);
        end
    endtask

    task automatic check_outs();
        chk("valid", 64'(o_valid), 64'(q.size() != 0));
        chk("count", 64'(o_count), 64'(q.size()));
        if (q.size() != 0) begin
            chk("pc", 64'(o_pc_ff), 64'(q[0].pc));
            chk("pc8", 64'(o_pc_plus_8_ff), 64'(q[0].pc8));
            chk("ins", 64'(o_instruction), 64'(q[0].ins));
            chk("side", 64'({o_taken_ff, o_irq, o_fiq, o_iabort, o_und, o_force32_align}),
                64'({q[0].tk, q[0].irq, q[0].fiq, q[0].iab, q[0].und, q[0].f32}));
        end else
            chk("side_idle", 64'({o_irq, o_fiq, o_iabort, o_und}), 64'(0));
    endtask

    task automatic cycle();
        logic exp_r;
        #1;
        if (!i_reset && !i_clear_from_writeback &&
            (i_data_stall || (!i_clear_from_alu && (i_stall_downstream || !i_clear_from_decode)))) begin
            exp_r = !i_data_stall && (q.size() < DEPTH || (!i_stall_downstream && q.size() > 0));
            chk("ready", 64'(o_ready), 64'(exp_r));
        end
        model_step();
        @(posedge i_clk);
        #1;
        check_outs();
    endtask

    task automatic clr();
        i_reset = 0; i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_downstream = 0; i_clear_from_decode = 0; i_valid = 0;
    endtask

    task automatic put(input logic [PCW-1:0] pc);
        i_valid = 1; i_pc_ff = pc; i_pc_plus_8_ff = pc + 8;
        i_instruction = IW'({$urandom, $urandom});
        i_taken = 2'($urandom);
        i_irq = 1'($urandom); i_fiq = 1'($urandom); i_iabort = 1'($urandom);
        i_und = 1'($urandom); i_force32_align = 1'($urandom);
    endtask

    initial begin
        i_reset = 1;
        cycle();
        clr();
        for (int i = 0; i < 3; i++) begin put(32'h100 + 2 * i); cycle(); end
        clr(); repeat (2) cycle();
        i_stall_downstream = 1;
        for (int i = 0; i < 5; i++) begin put(32'h100 + 2 * i); cycle(); end
        i_stall_downstream = 0; cycle();
        clr(); repeat (6) cycle();
        i_stall_downstream = 1;
        for (int i = 0; i < 4; i++) begin put(32'h200 + 2 * i); cycle(); end
        i_stall_downstream = 0; put(32'h300); cycle();
        clr(); repeat (5) cycle();
        i_stall_downstream = 1;
        for (int i = 0; i < 2; i++) begin put(32'h400 + 2 * i); cycle(); end
        clr(); i_data_stall = 1; i_clear_from_alu = 1; cycle();
        i_data_stall = 0; cycle();
        clr(); i_stall_downstream = 1;
        for (int i = 0; i < 2; i++) begin put(32'h500 + 2 * i); cycle(); end
        i_valid = 0; i_clear_from_decode = 1; cycle();
        clr(); i_clear_from_writeback = 1; i_data_stall = 1; cycle();
        clr(); put(32'h600); i_irq = 1; i_iabort = 1; i_stall_downstream = 1; cycle();
        clr(); i_clear_from_writeback = 1; put(32'h700); cycle();
        clr();
        for (int i = 0; i < 9; i++) begin put(32'h800 + 2 * i); cycle(); end
        clr(); repeat (3) cycle();
        for (int n = 0; n < 1500; n++) begin
            clr();
            if ($urandom_range(0, 1) == 1) put($urandom);
            i_reset                = $urandom_range(0, 63) == 0;
            i_clear_from_writeback = $urandom_range(0, 31) == 0;
            i_data_stall           = $urandom_range(0, 7) == 0;
            i_clear_from_alu       = $urandom_range(0, 31) == 0;
            i_stall_downstream     = $urandom_range(0, 2) == 0;
            i_clear_from_decode    = $urandom_range(0, 31) == 0;
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zap_predecode_queue.md
Name: zap_predecode_queue

Overview:
- Parametrised successor to the single-register Thumb predecode stage.
- Sits between the predecode/compress logic and the ARM decoder.
- Replaces the one-deep stall/clear register with a DEPTH-entry circular queue carrying instruction plus sideband (PC, PC+8, taken, irq, fiq, iabort, und, force32).
- Honours the same clear/stall priority chain, and adds back-pressure (o_ready) so fetch can run ahead while decode is stalled.

Parameters:
- IW, 35: instruction payload width.
- DEPTH, 4: number of queue entries; power of two, 2..16.
- PCW, 32: width of each PC field.

Ports:
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous active-high reset.
- i_clear_from_writeback  in  1  flush, highest priority after reset.
- i_data_stall  in  1  freeze entire queue.
- i_clear_from_alu  in  1  flush.
- i_stall_downstream  in  1  OR of shifter/issue/decode stalls; blocks pop only.
- i_clear_from_decode  in  1  flush, lowest priority.
- i_valid  in  1  push request.
- o_ready  out  1  queue can accept a push this cycle.
- i_instruction  in  IW  payload.
- i_pc_ff  in  PCW  PC of instruction.
- i_pc_plus_8_ff  in  PCW  PC+8.
- i_taken  in  2  predictor state.
- i_irq, i_fiq, i_iabort, i_und, i_force32_align  in  1 each  sideband.
- o_valid  out  1  head entry valid.
- o_instruction  out  IW  head payload.
- o_pc_ff, o_pc_plus_8_ff  out  PCW  head PCs.
- o_taken_ff  out  2  head predictor state.
- o_irq, o_fiq, o_iabort, o_und, o_force32_align  out  1 each  head sideband.
- o_count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- State: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count.
- Storage is a register array. Outputs are driven from the entry at rd_ptr (show-ahead).
- o_valid = (count != 0).
- o_irq, o_fiq, o_iabort, o_und are ANDed with o_valid.
- Other payload outputs are don't-care when o_valid = 0.
- o_ready = (count < DEPTH) OR (pop this cycle), where pop is computed from the priority chain below.
- pop = o_valid AND NOT i_stall_downstream, evaluated only when the cycle falls through to the normal row.
- push = i_valid AND o_ready, evaluated under the same condition.
- Per-cycle priority, first match wins:
  1. i_reset: wr_ptr = rd_ptr = count = 0. Storage is not cleared.
  2. i_clear_from_writeback: same as reset. Any push this cycle is dropped.
  3. i_data_stall: hold pointers and count. No push, no pop. o_ready = 0.
  4. i_clear_from_alu: flush, as in row 1.
  5. i_stall_downstream: no pop. Push allowed if count < DEPTH.
  6. i_clear_from_decode: flush.
  7. Otherwise: normal push/pop.
- Normal row:
  - Push writes all input fields into the entry at wr_ptr; wr_ptr increments.
  - Pop increments rd_ptr.
  - count += push − pop.
  - Simultaneous push and pop when full is legal; count stays DEPTH.
  - Simultaneous push and pop when empty: the new entry becomes visible the next cycle. There is no bypass, so latency is 1 cycle from push to o_valid.
- Interrupts are captured per entry at push time. A flush discards them; fetch re-samples the level-sensitive irq/fiq.
- A push while full and not popping is ignored. o_ready = 0 guarantees fetch does not issue it.
- Reset mid-operation has the same effect as row 1. All outputs qualified by o_valid read 0 in the cycle after reset.
- o_count == count at all times. It never exceeds DEPTH.

Test Plan:
- Reset, then push 3 entries with PCs 0x100, 0x102, 0x104 and no stalls → o_valid rises 1 cycle after the first push; heads appear in order; o_count peaks at 1.
- Hold i_stall_downstream = 1 and push 5 entries with DEPTH = 4 → o_count = 4; o_ready = 0 after the 4th push; the 5th is held. Release the stall → entries pop in order 0x100..0x106, then the 5th is accepted.
- Queue full at 4 entries; push and pop in the same cycle → o_count stays 4; head advances by one; the new entry lands at the old wr_ptr.
- i_data_stall = 1 together with i_clear_from_alu = 1 while holding 2 entries → no change for that cycle. Drop the stall → the flush happens next cycle; o_valid = 0 and o_count = 0.
- i_stall_downstream = 1 together with i_clear_from_decode = 1 → no flush; entries retained. i_clear_from_writeback = 1 with i_data_stall = 1 → flush.
- Push an entry with i_irq = 1 and i_iabort = 1, then flush with i_clear_from_writeback → o_irq = 0 and o_iabort = 0 next cycle. Pointer wraparound: perform 9 push/pop pairs with DEPTH = 4 → order preserved and no lost entries.
